fp_adder_pipe: RTL and testbench
================================

Name: fp_adder_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point adder/subtractor. Successor to the single-cycle fp32 adder in the reduction/accumulation datapath.
- Generalised in exponent and mantissa width, so FP32, BF16 and FP16 all come from one source.
- Adds a valid/ready handshake with full backpressure, an add/subtract mode, round-to-nearest-even, full subnormal support and exception flags.
- Sits between the multiplier array outputs and the reduction network.

Parameters:
- EXP_W, 8, exponent width (>=4).
- MAN_W, 23, stored fraction width (>=3); total word width W = 1+EXP_W+MAN_W.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  adder accepts operands this cycle.
- in_sub  in  1  0: O=A+B, 1: O=A-B (B sign inverted at unpack).
- A  in  W  operand A.
- B  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- O  out  W  result.
- flags  out  3  {invalid, overflow, inexact}, aligned with O.

Behaviour:
- Reset (async assert, sync release): all stage valids=0; out_valid=0, O=0, flags=0; in_ready=1 after reset deasserts. Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Pipeline has 3 register stages; latency 3 cycles from accepted input to out_valid, with no stalls.
  - S1: unpack, special-case detect, swap so |X|>=|Y|, align Y right by the exponent difference into MAN_W+4 bits (guard, round, sticky). Shift amounts >= MAN_W+3 saturate; all shifted-out bits OR into sticky.
  - S2: signed magnitude add/sub (one carry bit); leading-zero count via fp_lzc.
  - S3: normalise. On carry, shift right 1 and exp+1. Otherwise shift left by min(lzc, exp-1), so denormal results keep exp field 0. Then round RNE, re-normalise if rounding carries out, pack.
- Handshake: adv = !out_valid | out_ready; every stage advances together when adv=1; in_ready = adv. A transfer occurs when in_valid & in_ready.
  - Stall holds all stages. O and flags stay stable while out_valid & !out_ready.
  - Bubbles are not compressed (global stall). Full throughput is 1 op/cycle.
- Subnormal inputs (exp field 0): effective exponent 1, hidden bit 0. No flush-to-zero.
- Special cases, resolved in S1 and carried as a bypass tag:
  - Either operand NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 only for signalling NaN (fraction MSB 0).
  - +inf + -inf (after in_sub) -> canonical qNaN, invalid=1.
  - inf + finite, or inf + same-sign inf -> that inf, no flags.
  - Zero + zero -> -0 only if both effective signs are negative, else +0.
  - Exact cancellation of nonzero operands -> +0, inexact=0.
- Overflow: rounded exponent >= all-ones -> signed inf, overflow=1, inexact=1.
- inexact = (guard|round|sticky) != 0 before rounding, or overflow.
- Underflow is not flagged; tiny results are delivered as exact or rounded subnormals.

Decomposition:
- Package fp_pkg holds:
  - localparams W, BIAS, EXP_MAX (all ones) and the canonical qNaN pattern, each as a function of EXP_W/MAN_W;
  - the flag bit indices;
  - the special-case tag encoding {NONE, QNAN, INF_POS, INF_NEG, ZERO_POS, ZERO_NEG}.
- One sub-module: fp_lzc, a parametrised leading-zero counter (width MAN_W+5, output clog2 width), instantiated in S2.

Test Plan:
- FP32 basic: A=0x3F800000, B=0x3F800000, in_sub=0 -> O=0x40000000, flags=0, out_valid exactly 3 cycles after accept.
- RNE tie: A=0x3F800000, B=0x33800000 -> O=0x3F800000, inexact=1. B=0x33C00000 -> O=0x3F800001, inexact=1.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=3'b011.
  - 0x80000000 + 0x80000000 -> 0x80000000.
  - 0x3F800000 - 0x3F800000 -> 0x00000000.
- Subnormal: 0x00000001 + 0x00000001 -> 0x00000002. 0x00800000 - 0x00000001 -> 0x007FFFFF, inexact=0.
- Backpressure: stream 8 random pairs with out_ready toggled pseudo-randomly -> results in order, matching a C reference model; O stable during stalls; no loss or duplication.
- Reset: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately; after release no stale output appears. Repeat the basic test with EXP_W=8, MAN_W=7 (BF16): 0x3F80 + 0x3F80 -> 0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point adder:
// flag bit positions, special-case bypass tags and format helpers.
package fp_pkg;

    // Bit positions within the 3-bit flags output {invalid, overflow, inexact}
    localparam int unsigned FLAG_INEXACT  = 0;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_INVALID  = 2;
    localparam int unsigned FLAG_W        = 3;

    // Special-case result carried down the pipeline alongside the datapath
    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_QNAN,
        TAG_INF_POS,
        TAG_INF_NEG,
        TAG_ZERO_POS,
        TAG_ZERO_NEG
    } fp_tag_e;

    // Total word width W = sign + exponent + stored fraction
    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Exponent bias for a given exponent width
    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // All-ones exponent field (inf / NaN)
    function automatic int unsigned fp_exp_max(input int unsigned exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN (sign 0, exponent all ones, fraction MSB only),
    // right-aligned in a 64-bit container; callers keep the low W bits.
    function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = man_w - 1; i < man_w + exp_w; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the highest set bit determines the final count
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_adder_pipe.sv
// Three-stage IEEE-754 adder/subtractor, RNE rounding, subnormals kept,
// global-stall valid/ready handshake.
module fp_adder_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sub,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   O,
    output logic [2:0]             flags
);

    localparam int unsigned W   = fp_width(EXP_W, MAN_W);
    localparam int unsigned SW  = MAN_W + 4;      // hidden + fraction + G/R/S
    localparam int unsigned NW  = MAN_W + 5;      // plus carry bit
    localparam int unsigned CW  = $clog2(NW + 1);
    localparam int unsigned SAT = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_MAX   = EXP_W'(fp_exp_max(EXP_W));
    localparam logic [63:0]      QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_WIDE[W-1:0];

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic                 sa, sb, a_ge_b;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa     = A[W-1];
    assign sb     = B[W-1] ^ in_sub;
    assign ea     = A[W-2:MAN_W];
    assign eb     = B[W-2:MAN_W];
    assign fa     = A[MAN_W-1:0];
    assign fb     = B[MAN_W-1:0];
    assign a_nan  = (ea == EXP_MAX) && (fa != '0);
    assign b_nan  = (eb == EXP_MAX) && (fb != '0);
    assign a_inf  = (ea == EXP_MAX) && (fa == '0);
    assign b_inf  = (eb == EXP_MAX) && (fb == '0);
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);
    assign a_ge_b = A[W-2:0] >= B[W-2:0];

    logic                 sx;
    logic [EXP_W-1:0]     ex_f, ey_f, ex, ey, diff;
    logic [MAN_W-1:0]     fx, fy;
    logic [MAN_W:0]       mx, my;
    logic [31:0]          sh;
    logic [2*SW-1:0]      y_ext;
    logic [SW-1:0]        x_al, y_al;
    fp_tag_e              tag1;
    logic                 inv1;

    // Order operands by magnitude, right-shift the smaller one with sticky, tag specials
    always_comb begin
        sx    = a_ge_b ? sa : sb;
        ex_f  = a_ge_b ? ea : eb;
        ey_f  = a_ge_b ? eb : ea;
        fx    = a_ge_b ? fa : fb;
        fy    = a_ge_b ? fb : fa;
        ex    = (ex_f == '0) ? EXP_W'(1) : ex_f;
        ey    = (ey_f == '0) ? EXP_W'(1) : ey_f;
        mx    = {ex_f != '0, fx};
        my    = {ey_f != '0, fy};
        diff  = ex - ey;
        sh    = (32'(diff) >= SAT) ? SAT : 32'(diff);
        // Low half of y_ext catches every bit shifted past the sticky position
        y_ext = {my, 3'b000, {SW{1'b0}}} >> sh;
        x_al  = {mx, 3'b000};
        y_al  = {y_ext[2*SW-1:SW+1], y_ext[SW] | (|y_ext[SW-1:0])};

        tag1 = TAG_NONE;
        inv1 = 1'b0;
        if (a_nan || b_nan) begin
            tag1 = TAG_QNAN;
            inv1 = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
        end else if (a_inf && b_inf && (sa != sb)) begin
            tag1 = TAG_QNAN;
            inv1 = 1'b1;
        end else if (a_inf) begin
            tag1 = sa ? TAG_INF_NEG : TAG_INF_POS;
        end else if (b_inf) begin
            tag1 = sb ? TAG_INF_NEG : TAG_INF_POS;
        end else if (a_zero && b_zero) begin
            tag1 = (sa && sb) ? TAG_ZERO_NEG : TAG_ZERO_POS;
        end
    end

    logic                 s1_valid, s1_inv, s1_sign, s1_sub;
    fp_tag_e              s1_tag;
    logic [EXP_W-1:0]     s1_exp;
    logic [SW-1:0]        s1_x, s1_y;

    // Stage-1 register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= TAG_NONE;
            s1_inv   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_tag   <= tag1;
            s1_inv   <= inv1;
            s1_sign  <= sx;
            s1_sub   <= (sa != sb);
            s1_exp   <= ex;
            s1_x     <= x_al;
            s1_y     <= y_al;
        end
    end

    // ---------------- S2: magnitude add/sub, leading-zero count ----------------
    logic [NW-1:0] sum2;
    logic [CW-1:0] lzc2;

    assign sum2 = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});

    fp_lzc #(.WIDTH(NW), .CNT_W(CW)) u_lzc (
        .din (sum2),
        .cnt (lzc2)
    );

    logic                 s2_valid, s2_inv, s2_sign;
    fp_tag_e              s2_tag;
    logic [EXP_W-1:0]     s2_exp;
    logic [NW-1:0]        s2_sum;
    logic [CW-1:0]        s2_lzc;

    // Stage-2 register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_tag   <= TAG_NONE;
            s2_inv   <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_sum   <= '0;
            s2_lzc   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_inv   <= s1_inv;
            s2_sign  <= s1_sign;
            s2_exp   <= s1_exp;
            s2_sum   <= sum2;
            s2_lzc   <= lzc2;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [EXP_W:0]   e_base, lz_ext, e_room, shamt, e_norm, e_fin;
    logic [SW-1:0]    mant;
    logic [MAN_W+1:0] rnd;
    logic             grs_any, rup;
    logic [W-1:0]     o_nxt;
    logic [2:0]       f_nxt;

    // Normalise (left shift capped so subnormals keep exponent 1), RNE, overflow, specials
    always_comb begin
        e_base = {1'b0, s2_exp};
        lz_ext = (EXP_W+1)'(s2_lzc) - (EXP_W+1)'(1);   // zeros below the carry bit
        e_room = e_base - (EXP_W+1)'(1);
        shamt  = '0;
        if (s2_sum[NW-1]) begin
            mant   = {s2_sum[NW-1:2], s2_sum[1] | s2_sum[0]};
            e_norm = e_base + (EXP_W+1)'(1);
        end else begin
            shamt  = (lz_ext < e_room) ? lz_ext : e_room;
            mant   = s2_sum[SW-1:0] << shamt;
            e_norm = e_base - shamt;
        end

        grs_any = |mant[2:0];
        rup     = mant[2] && (mant[1] || mant[0] || mant[3]);
        rnd     = {1'b0, mant[SW-1:3]} + (MAN_W+2)'(rup);

        // Hidden bit absent after rounding means the result stays subnormal
        if (rnd[MAN_W+1]) begin
            e_fin = e_norm + (EXP_W+1)'(1);
        end else if (rnd[MAN_W]) begin
            e_fin = e_norm;
        end else begin
            e_fin = '0;
        end

        f_nxt = '0;
        if (e_fin >= {1'b0, EXP_MAX}) begin
            o_nxt = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
            f_nxt[FLAG_OVERFLOW] = 1'b1;
            f_nxt[FLAG_INEXACT]  = 1'b1;
        end else begin
            o_nxt = {s2_sign, e_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
            f_nxt[FLAG_INEXACT] = grs_any;
        end

        if (s2_sum == '0) begin
            o_nxt = '0;
            f_nxt = '0;
        end

        case (s2_tag)
            TAG_QNAN: begin
                o_nxt = QNAN;
                f_nxt = '0;
                f_nxt[FLAG_INVALID] = s2_inv;
            end
            TAG_INF_POS: begin
                o_nxt = {1'b0, EXP_MAX, {MAN_W{1'b0}}};
                f_nxt = '0;
            end
            TAG_INF_NEG: begin
                o_nxt = {1'b1, EXP_MAX, {MAN_W{1'b0}}};
                f_nxt = '0;
            end
            TAG_ZERO_POS: begin
                o_nxt = '0;
                f_nxt = '0;
            end
            TAG_ZERO_NEG: begin
                o_nxt = {1'b1, {(W-1){1'b0}}};
                f_nxt = '0;
            end
            default: ;
        endcase
    end

    // Output register; holds O/flags while the consumer stalls
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            O         <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            O         <= o_nxt;
            flags     <= f_nxt;
        end
    end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed and backpressure bench for fp_adder_pipe (FP32 and BF16 instances).
module tb_fp_adder_pipe;

    logic        CLK;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] A, B, O;
    logic [2:0]  flags;

    logic        bf_in_valid, bf_in_ready, bf_in_sub, bf_out_valid, bf_out_ready;
    logic [15:0] bf_A, bf_B, bf_O;
    logic [2:0]  bf_flags;

    int tests = 0;
    int fails = 0;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .O(O), .flags(flags)
    );

    fp_adder_pipe #(.EXP_W(8), .MAN_W(7)) dut_bf (
        .CLK(CLK), .rst_n(rst_n), .in_valid(bf_in_valid), .in_ready(bf_in_ready),
        .in_sub(bf_in_sub), .A(bf_A), .B(bf_B), .out_valid(bf_out_valid),
        .out_ready(bf_out_ready), .O(bf_O), .flags(bf_flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Exact-integer reference for normal FP32 operands with exponent fields 112..140
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint      va, vb, s;
        logic [63:0] mag, keep, rem, half;
        int          p, sh;
        logic        inx;
        va = longint'({40'd0, 1'b1, a[22:0]}) << (int'(a[30:23]) - 112);
        vb = longint'({40'd0, 1'b1, b[22:0]}) << (int'(b[30:23]) - 112);
        if (a[31]) va = -va;
        if (b[31] ^ sub) vb = -vb;
        s = va + vb;
        if (s == 0) return 33'd0;
        mag = (s < 0) ? 64'(-s) : 64'(s);
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        inx = 1'b0;
        if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 64'd0);
            if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
            if (keep[24]) begin
                keep = keep >> 1;
                p    = p + 1;
            end
        end else begin
            keep = mag << (23 - p);
        end
        return {inx, (s < 0), 8'(p + 89), keep[22:0]};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_o, input logic [2:0] exp_f);
        int lat;
        @(negedge CLK);
        A = a; B = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "/rdy"}, 32'(in_ready), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, "/lat"}, 32'(lat), 32'd3);
        check({tag, "/O"}, O, exp_o);
        check({tag, "/flags"}, 32'(flags), 32'(exp_f));
    endtask

    logic [31:0] bp_a [8];
    logic [31:0] bp_b [8];
    logic        bp_s [8];
    logic [32:0] bp_e [8];
    logic [31:0] held;
    logic        stalled, acc;
    int          sent, recv, extra, lat;
    logic [7:0]  ea, eb;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        bf_in_valid = 1'b0; bf_in_sub = 1'b0; bf_A = '0; bf_B = '0; bf_out_ready = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/O", O, 32'd0);
        check("rst/flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst/in_ready", 32'(in_ready), 32'd1);

        run_op("basic",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        run_op("rne_tie",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run_op("rne_up",    32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001);
        run_op("inf_minf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("inf_subinf",32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        run_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        run_op("negzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run_op("mixzero",   32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
        run_op("cancel",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        run_op("sub_neg",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
        run_op("denorm_add",32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        run_op("denorm_sub",32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        run_op("snan",      32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_op("qnan",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        run_op("ninf_fin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);

        // Backpressure stream: random pairs, random out_ready
        for (int i = 0; i < 8; i++) begin
            ea = 8'($urandom_range(112, 140));
            eb = (i % 2 == 1) ? 8'($urandom_range(112, 140)) : ea;
            bp_a[i] = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
            bp_b[i] = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
            bp_s[i] = 1'($urandom_range(0, 1));
            bp_e[i] = ref_add(bp_a[i], bp_b[i], bp_s[i]);
        end
        sent = 0; recv = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            @(negedge CLK);
            in_valid = (sent < 8);
            if (sent < 8) begin
                A = bp_a[sent]; B = bp_b[sent]; in_sub = bp_s[sent];
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                check("bp/hold_valid", 32'(out_valid), 32'd1);
                check("bp/hold_O", O, held);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp%0d/O", recv), O, bp_e[recv][31:0]);
                check($sformatf("bp%0d/flags", recv), 32'(flags), {31'd0, bp_e[recv][32]});
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = O;
            acc     = in_valid && in_ready;
            @(posedge CLK);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp/count", 32'(recv), 32'd8);
        extra = 0;
        repeat (6) begin
            @(negedge CLK);
            if (out_valid) extra++;
        end
        check("bp/no_dup", 32'(extra), 32'd0);

        // Reset with three operations in flight
        @(negedge CLK);
        out_ready = 1'b0; in_valid = 1'b1; in_sub = 1'b0;
        A = 32'h3F800000; B = 32'h3F800000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        check("rst_mid/full", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/out_valid", 32'(out_valid), 32'd0);
        check("rst_mid/O", O, 32'd0);
        check("rst_mid/flags", 32'(flags), 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge CLK);
            if (out_valid) extra++;
        end
        check("rst_mid/stale", 32'(extra), 32'd0);
        check("rst_mid/in_ready", 32'(in_ready), 32'd1);

        // BF16 instance
        @(negedge CLK);
        bf_A = 16'h3F80; bf_B = 16'h3F80; bf_in_sub = 1'b0; bf_in_valid = 1'b1; bf_out_ready = 1'b1;
        #1;
        check("bf16/rdy", 32'(bf_in_ready), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bf_in_valid = 1'b0;
        lat = 1;
        while (!bf_out_valid && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        check("bf16/lat", 32'(lat), 32'd3);
        check("bf16/O", 32'(bf_O), 32'h4000);
        check("bf16/flags", 32'(bf_flags), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
